// File: rtl/simon_cfg_regs.sv
// AXI4-Lite configuration register file for the Simon cipher core.
// Holds the 128-bit key and control bits, issues the start pulse, tracks
// sticky done/err status and drives a level interrupt back to software.
module simon_cfg_regs #(
  parameter int          CFG_ADDR_WIDTH = 12,
  parameter int          CFG_DATA_WIDTH = 32,
  parameter int          CFG_STRB_WIDTH = 4,
  parameter int          CFG_PROT_WIDTH = 3,
  parameter int          CFG_RESP_WIDTH = 2,
  parameter logic [31:0] VERSION        = 32'h5349_0100
) (
  input  logic                      simon_cfg_clk,
  input  logic                      simon_cfg_rstn,
  input  logic [CFG_ADDR_WIDTH-1:0] simon_cfg_awaddr,
  input  logic [CFG_PROT_WIDTH-1:0] simon_cfg_awprot,
  input  logic                      simon_cfg_awvalid,
  output logic                      simon_cfg_awready,
  input  logic [CFG_DATA_WIDTH-1:0] simon_cfg_wdata,
  input  logic [CFG_STRB_WIDTH-1:0] simon_cfg_wstrb,
  input  logic                      simon_cfg_wvalid,
  output logic                      simon_cfg_wready,
  output logic [CFG_RESP_WIDTH-1:0] simon_cfg_bresp,
  output logic                      simon_cfg_bvalid,
  input  logic                      simon_cfg_bready,
  input  logic [CFG_ADDR_WIDTH-1:0] simon_cfg_araddr,
  input  logic [CFG_PROT_WIDTH-1:0] simon_cfg_arprot,
  input  logic                      simon_cfg_arvalid,
  output logic                      simon_cfg_arready,
  output logic [CFG_DATA_WIDTH-1:0] simon_cfg_rdata,
  output logic [CFG_RESP_WIDTH-1:0] simon_cfg_rresp,
  output logic                      simon_cfg_rvalid,
  input  logic                      simon_cfg_rready,
  output logic [127:0]              key_o,
  output logic                      decrypt_o,
  output logic                      start_o,
  input  logic                      busy_i,
  input  logic                      done_i,
  output logic                      irq_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge
  // where valid and ready are both 1; a source holds valid and payload
  // stable until that edge, and readies here are registered outputs.

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [CFG_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [CFG_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  logic [0:0]                w_state, r_state;
  logic                      aw_held, w_held;
  logic [CFG_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;
  logic                      awready_q, wready_q, arready_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [31:0]               rdata_q;

  logic [3:0][31:0]          key_q;
  logic                      decrypt_q, irq_en_q, done_q, err_q, start_q, irq_q;

  logic                      aw_hs, w_hs, ar_hs, wr_fire;
  logic [CFG_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]               wr_data;
  logic [3:0]                wr_strb;
  logic                      wr_hit, rd_hit;
  logic                      ctrl_wr, stat_wr, start_go, start_rej, clr_done, clr_err;
  logic [3:0]                key_wr;
  logic [31:0]               rd_val;
  logic                      unused_ok;

  // A hit needs every address bit above the decoded window clear and an offset up to VERSION.
  function automatic logic addr_hit(input logic [CFG_ADDR_WIDTH-1:0] a);
    return (a[CFG_ADDR_WIDTH-1:5] == '0) && (a[4:2] <= 3'd6);
  endfunction

  assign aw_hs   = simon_cfg_awvalid & awready_q;
  assign w_hs    = simon_cfg_wvalid & wready_q;
  assign ar_hs   = simon_cfg_arvalid & arready_q;
  assign wr_fire = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_addr = aw_hs ? simon_cfg_awaddr : aw_addr_q;
  assign wr_data = w_hs ? simon_cfg_wdata : w_data_q;
  assign wr_strb = w_hs ? simon_cfg_wstrb : w_strb_q;
  assign wr_hit  = addr_hit(wr_addr);
  assign rd_hit  = addr_hit(simon_cfg_araddr);

  // Decode the committing write into per-register strobes; W1C and start act only with byte 0 enabled.
  always_comb begin
    ctrl_wr   = wr_fire & wr_hit & (wr_addr[4:2] == 3'd0) & wr_strb[0];
    stat_wr   = wr_fire & wr_hit & (wr_addr[4:2] == 3'd1) & wr_strb[0];
    start_go  = ctrl_wr & wr_data[0] & ~busy_i;
    start_rej = ctrl_wr & wr_data[0] & busy_i;
    clr_done  = stat_wr & wr_data[1];
    clr_err   = stat_wr & wr_data[2];
    key_wr    = '0;
    for (int k = 0; k < 4; k++) begin
      key_wr[k] = wr_fire & wr_hit & (wr_addr[4:2] == 3'(k + 2));
    end
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rd_val = '0;
    case (simon_cfg_araddr[4:2])
      3'd0:    rd_val = {29'd0, irq_en_q, decrypt_q, 1'b0};
      3'd1:    rd_val = {29'd0, err_q, done_q, busy_i};
      3'd2:    rd_val = key_q[0];
      3'd3:    rd_val = key_q[1];
      3'd4:    rd_val = key_q[2];
      3'd5:    rd_val = key_q[3];
      3'd6:    rd_val = VERSION;
      default: rd_val = '0;
    endcase
    if (!rd_hit) rd_val = '0;
  end

  // Write FSM: capture AW and W independently, commit once both are held, then hold the response.
  always_ff @(posedge simon_cfg_clk or negedge simon_cfg_rstn) begin
    if (!simon_cfg_rstn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            w_state   <= W_RESP;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= simon_cfg_awaddr;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= simon_cfg_wdata;
              w_strb_q <= simon_cfg_wstrb;
            end
            awready_q <= ~(aw_held | aw_hs);
            wready_q  <= ~(w_held | w_hs);
          end
        end
        W_RESP: begin
          if (simon_cfg_bready) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Register file update: byte-enabled key/ctrl writes, sticky status where a set beats a clear.
  always_ff @(posedge simon_cfg_clk or negedge simon_cfg_rstn) begin
    if (!simon_cfg_rstn) begin
      key_q     <= '0;
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      start_q <= start_go;
      if (ctrl_wr) begin
        decrypt_q <= wr_data[1];
        irq_en_q  <= wr_data[2];
      end
      done_q <= (done_q & ~clr_done) | done_i;
      err_q  <= (err_q & ~clr_err) | start_rej;
      irq_q  <= done_q & irq_en_q;
      for (int k = 0; k < 4; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (key_wr[k] && wr_strb[b]) key_q[k][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read FSM: register data on the address handshake and hold it until the master takes it.
  always_ff @(posedge simon_cfg_clk or negedge simon_cfg_rstn) begin
    if (!simon_cfg_rstn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state   <= R_DATA;
            arready_q <= 1'b0;
            rdata_q   <= rd_val;
            rresp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (simon_cfg_rready) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign simon_cfg_awready = awready_q;
  assign simon_cfg_wready  = wready_q;
  assign simon_cfg_bvalid  = (w_state == W_RESP);
  assign simon_cfg_bresp   = bresp_q;
  assign simon_cfg_arready = arready_q;
  assign simon_cfg_rvalid  = (r_state == R_DATA);
  assign simon_cfg_rdata   = rdata_q;
  assign simon_cfg_rresp   = rresp_q;
  assign key_o             = key_q;
  assign decrypt_o         = decrypt_q;
  assign start_o           = start_q;
  assign irq_o             = irq_q;

  // Protection bits and byte-lane address bits carry no meaning for this block.
  assign unused_ok = ^{simon_cfg_awprot, simon_cfg_arprot, wr_addr[1:0], simon_cfg_araddr[1:0],
                       wr_data[31:3]};

endmodule
